// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a word-count header and little-endian
// 32-bit words over a byte stream, writes them to instruction memory, and holds
// the core in reset until the whole image has been written.
module instr_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_masking,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_w_data,
    input  logic              mem_valid,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LEN_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        RECV  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  hdr_lo;
    logic [15:0] n_words;
    logic [23:0] word_buf;

    logic        rx_fire_c;
    logic [15:0] hdr_n_c;
    logic        hdr_bad_c;
    logic        last_word_c;

    // Handshake and header/length decode shared by the state machine
    assign rx_fire_c   = rx_valid && rx_ready;
    assign hdr_n_c     = {rx_data, hdr_lo};
    assign hdr_bad_c   = (hdr_n_c == 16'd0) || (LEN_W'(hdr_n_c) > LEN_W'(DEPTH));
    assign last_word_c = (LEN_W'(words_loaded) + LEN_W'(1)) == LEN_W'(n_words);

    // Load sequencer: header parse, byte assembly and memory write handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            hdr_lo       <= 8'd0;
            n_words      <= 16'd0;
            word_buf     <= 24'd0;
            rx_ready     <= 1'b0;
            mem_request  <= 1'b0;
            mem_we_re    <= 1'b0;
            mem_masking  <= 4'd0;
            mem_address  <= '0;
            mem_w_data   <= 32'd0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b0;
                    if (start) begin
                        state        <= HDR;
                        rx_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        core_rst     <= 1'b1;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
                    end
                end

                HDR: begin
                    if (rx_fire_c) begin
                        if (byte_cnt == 2'd0) begin
                            hdr_lo   <= rx_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            byte_cnt <= 2'd0;
                            if (hdr_bad_c) begin
                                state    <= IDLE;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                                rx_ready <= 1'b0;
                            end else begin
                                n_words <= hdr_n_c;
                                state   <= RECV;
                            end
                        end
                    end
                end

                RECV: begin
                    if (rx_fire_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word; launch the write
                                mem_w_data  <= {rx_data, word_buf};
                                mem_address <= words_loaded[ADDR_W-1:0];
                                mem_request <= 1'b1;
                                mem_we_re   <= 1'b1;
                                mem_masking <= 4'b1111;
                                rx_ready    <= 1'b0;
                                state       <= WRITE;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    if (mem_valid) begin
                        mem_request  <= 1'b0;
                        mem_we_re    <= 1'b0;
                        mem_masking  <= 4'd0;
                        words_loaded <= words_loaded + CNT_W'(1);
                        if (last_word_c) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            core_rst <= 1'b0;
                        end else begin
                            state    <= RECV;
                            rx_ready <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized images and stream/memory
// timing, compared against an image-level reference of expected writes.
module tb_instr_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_request;
    logic              mem_we_re;
    logic [3:0]        mem_masking;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_w_data;
    logic              mem_valid;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    // Memory responder / monitor state
    int  mem_delay   = 0;
    bit  stray_valid = 0;
    int  gap_max     = 0;
    int  req_age     = 0;
    int  req_seen    = 0;
    int  unstable    = 0;
    int  rdy_in_write = 0;
    int  inv_bad     = 0;
    int  cyc         = 0;
    int  last_cyc    = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    int                log_hold[$];
    logic [31:0]       img[$];

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_request  (mem_request),
        .mem_we_re    (mem_we_re),
        .mem_masking  (mem_masking),
        .mem_address  (mem_address),
        .mem_w_data   (mem_w_data),
        .mem_valid    (mem_valid),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial forever #5 clk = ~clk;

    // Observe the memory interface at each active edge and log completed writes
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mem_request === 1'b1) begin
            req_seen++;
            if (rx_ready === 1'b1) rdy_in_write++;
            if (req_age > 0 && (mem_address !== prev_addr || mem_w_data !== prev_data)) unstable++;
            if (mem_we_re !== 1'b1 || mem_masking !== 4'hf) unstable++;
            prev_addr = mem_address;
            prev_data = mem_w_data;
            if (mem_valid) begin
                log_addr.push_back(mem_address);
                log_data.push_back(mem_w_data);
                log_hold.push_back(req_age + 1);
                req_age = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    // Memory completes a request after mem_delay wait cycles; optional noise otherwise
    always @(negedge clk) begin
        if (mem_request === 1'b1) mem_valid = (req_age >= mem_delay);
        else mem_valid = stray_valid ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (core_rst !== ~done) inv_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_hold.delete();
        req_seen = 0;
        unstable = 0;
        rdy_in_write = 0;
        inv_bad = 0;
    endtask

    // Offer one byte until accepted (bounded), then an optional random gap
    task automatic send_byte(input logic [7:0] b);
        int t;
        bit ok;
        t = 0;
        ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!ok && t < 200) begin
            @(posedge clk);
            if (rx_ready === 1'b1) ok = 1;
            else t++;
        end
        last_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted, got timeout required rx_ready", b);
        end
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full load: start, header n, then nwords words from img; returns first-byte cycle
    task automatic run_load(input logic [15:0] n, input int nwords, output int first);
        @(negedge clk);
        pulse_start();
        send_byte(n[7:0]);
        first = last_cyc;
        send_byte(n[15:8]);
        for (int i = 0; i < nwords; i++) send_word(img[i]);
    endtask

    task automatic wait_idle(output int t_end);
        int t;
        t = 0;
        while (busy === 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        t_end = cyc;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 0 within bound", busy);
        end
    endtask

    task automatic test_reset();
        logic [59:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {rx_ready, mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
               core_rst, busy, done, err, words_loaded};
        checks++;
        if (obs !== {3'b000, 4'h0, 8'h00, 32'h0, 1'b1, 3'b000, 9'h000}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", obs,
                     {3'b000, 4'h0, 8'h00, 32'h0, 1'b1, 3'b000, 9'h000});
        end
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rx_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_consume: rx_ready=%b busy=%b required 0 0", rx_ready, busy);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_three_words();
        int first, t_end;
        mem_delay = 0; gap_max = 0; stray_valid = 0;
        img = '{32'h00500013, 32'h00A00093, 32'h00208133};
        clear_log();
        run_load(16'd3, 3, first);
        wait_idle(t_end);
        checks++;
        if (log_addr.size() !== 3) begin
            errors++;
            $display("FAIL three_count: got %0d writes required 3", log_addr.size());
        end
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== img[i]) begin
                errors++;
                $display("FAIL three_write%0d: got %h@%0d required %h@%0d", i, log_data[i], log_addr[i], img[i], i);
            end
        end
        checks++;
        if ({done, err, core_rst, words_loaded} !== {3'b100, 9'd3}) begin
            errors++;
            $display("FAIL three_status: done=%b err=%b core_rst=%b wl=%0d required 1 0 0 3", done, err, core_rst, words_loaded);
        end
        checks++;
        if (t_end - first !== 2 + 5 * 3) begin
            errors++;
            $display("FAIL three_latency: got %0d cycles required %0d", t_end - first, 2 + 5 * 3);
        end
        checks++;
        if (inv_bad !== 0) begin
            errors++;
            $display("FAIL three_core_rst_vs_done: got %0d samples with core_rst==done required 0", inv_bad);
        end
    endtask

    task automatic test_bad_header_zero();
        clear_log();
        @(negedge clk);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({busy, err, done, core_rst} !== 4'b0101) begin
            errors++;
            $display("FAIL hdr_zero_status: busy=%b err=%b done=%b core_rst=%b required 0 1 0 1", busy, err, done, core_rst);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_seen !== 0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL hdr_zero_quiet: req_cycles=%0d rx_ready=%b required 0 0", req_seen, rx_ready);
        end
    endtask

    task automatic test_bad_header_big();
        int first, t_end;
        clear_log();
        img = '{$urandom};
        run_load(16'h0101, 0, first);
        wait_idle(t_end);
        checks++;
        if (err !== 1'b1 || req_seen !== 0) begin
            errors++;
            $display("FAIL hdr_big: err=%b req_cycles=%0d required 1 0", err, req_seen);
        end
        clear_log();
        run_load(16'h0001, 1, first);
        wait_idle(t_end);
        checks++;
        if ({err, done, words_loaded} !== {2'b01, 9'd1} || log_data.size() !== 1) begin
            errors++;
            $display("FAIL hdr_followup: err=%b done=%b wl=%0d writes=%0d required 0 1 1 1", err, done, words_loaded, log_data.size());
        end else begin
            checks++;
            if (log_data[0] !== img[0] || log_addr[0] !== '0) begin
                errors++;
                $display("FAIL hdr_followup_data: got %h@%0d required %h@0", log_data[0], log_addr[0], img[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int first, t_end;
        mem_delay = 3; gap_max = 0; stray_valid = 0;
        img = '{$urandom, $urandom};
        clear_log();
        run_load(16'd2, 2, first);
        wait_idle(t_end);
        for (int i = 0; i < 2 && i < log_hold.size(); i++) begin
            checks++;
            if (log_hold[i] !== 4 || log_data[i] !== img[i] || log_addr[i] !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL bp_write%0d: hold=%0d data=%h addr=%0d required 4 %h %0d", i, log_hold[i], log_data[i], log_addr[i], img[i], i);
            end
        end
        checks++;
        if (unstable !== 0 || rdy_in_write !== 0 || log_hold.size() !== 2) begin
            errors++;
            $display("FAIL bp_stable: unstable=%0d rdy_in_write=%0d writes=%0d required 0 0 2", unstable, rdy_in_write, log_hold.size());
        end
        mem_delay = 0;
    endtask

    task automatic test_gaps_and_start();
        int t_end;
        logic [31:0] w0;
        mem_delay = 1; gap_max = 0; stray_valid = 1;
        img = '{$urandom, $urandom};
        w0 = img[0];
        clear_log();
        @(negedge clk);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(w0[7:0]);
        send_byte(w0[15:8]);
        @(negedge clk);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || words_loaded !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_in_recv: busy=%b wl=%0d err=%b required 1 0 0", busy, words_loaded, err);
        end
        gap_max = 2;
        send_byte(w0[23:16]);
        send_byte(w0[31:24]);
        send_word(img[1]);
        wait_idle(t_end);
        for (int i = 0; i < 2 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== img[i] || log_addr[i] !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL gaps_write%0d: got %h@%0d required %h@%0d", i, log_data[i], log_addr[i], img[i], i);
            end
        end
        checks++;
        if ({done, words_loaded} !== {1'b1, 9'd2} || log_data.size() !== 2) begin
            errors++;
            $display("FAIL gaps_status: done=%b wl=%0d writes=%0d required 1 2 2", done, words_loaded, log_data.size());
        end
        stray_valid = 0; gap_max = 0; mem_delay = 0;
    endtask

    task automatic test_random_loads();
        int first, t_end, pick, n, bad_cnt;
        bit bad;
        for (int r = 0; r < 6; r++) begin
            pick = $urandom_range(0, 7);
            n = (pick == 7) ? 257 + $urandom_range(0, 200) : pick;
            bad = (n == 0) || (n > DEPTH);
            mem_delay = $urandom_range(0, 2);
            gap_max = $urandom_range(0, 2);
            stray_valid = 1;
            img.delete();
            for (int i = 0; i < (bad ? 0 : n); i++) img.push_back($urandom);
            clear_log();
            run_load(16'(n), bad ? 0 : n, first);
            wait_idle(t_end);
            checks++;
            if (err !== bad || done !== !bad || core_rst !== bad ||
                words_loaded !== (bad ? 9'd0 : 9'(n)) || log_data.size() !== (bad ? 0 : n)) begin
                errors++;
                $display("FAIL rand%0d_status n=%0d: err=%b done=%b core_rst=%b wl=%0d writes=%0d", r, n, err, done, core_rst, words_loaded, log_data.size());
            end
            bad_cnt = 0;
            for (int i = 0; i < log_data.size() && i < img.size(); i++)
                if (log_data[i] !== img[i] || log_addr[i] !== ADDR_W'(i)) bad_cnt++;
            checks++;
            if (bad_cnt !== 0) begin
                errors++;
                $display("FAIL rand%0d_data: got %0d wrong writes required 0", r, bad_cnt);
            end
        end
        stray_valid = 0; gap_max = 0; mem_delay = 0;
    endtask

    task automatic test_full_depth();
        int first, t_end, bad_cnt;
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        clear_log();
        run_load(16'(DEPTH), DEPTH, first);
        wait_idle(t_end);
        checks++;
        if (words_loaded !== 9'h100 || done !== 1'b1 || log_addr.size() !== DEPTH) begin
            errors++;
            $display("FAIL full_status: wl=%h done=%b writes=%0d required 100 1 %0d", words_loaded, done, log_addr.size(), DEPTH);
        end
        bad_cnt = 0;
        for (int i = 0; i < log_data.size() && i < DEPTH; i++)
            if (log_data[i] !== img[i] || log_addr[i] !== ADDR_W'(i)) bad_cnt++;
        checks++;
        if (bad_cnt !== 0 || log_addr[log_addr.size()-1] !== 8'hFF) begin
            errors++;
            $display("FAIL full_data: wrong=%0d last_addr=%0d required 0 255", bad_cnt, log_addr[log_addr.size()-1]);
        end
    endtask

    task automatic test_reset_midload();
        logic [59:0] obs;
        logic [31:0] w1;
        int t, first, t_end;
        img = '{$urandom, $urandom, $urandom};
        w1 = img[1];
        clear_log();
        @(negedge clk);
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_word(img[0]);
        t = 0;
        while (log_addr.size() < 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        #2 rst = 1'b1;
        #1;
        obs = {rx_ready, mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
               core_rst, busy, done, err, words_loaded};
        checks++;
        if (obs !== {3'b000, 4'h0, 8'h00, 32'h0, 1'b1, 3'b000, 9'h000} || log_addr.size() !== 1) begin
            errors++;
            $display("FAIL midload_reset: got %h writes=%0d required %h 1", obs, log_addr.size(),
                     {3'b000, 4'h0, 8'h00, 32'h0, 1'b1, 3'b000, 9'h000});
        end
        @(negedge clk);
        rst = 1'b0;
        img = '{$urandom, $urandom};
        clear_log();
        run_load(16'd2, 2, first);
        wait_idle(t_end);
        checks++;
        if ({done, core_rst, words_loaded} !== {2'b10, 9'd2} || log_data.size() !== 2) begin
            errors++;
            $display("FAIL after_reset_load: done=%b core_rst=%b wl=%0d writes=%0d required 1 0 2 2", done, core_rst, words_loaded, log_data.size());
        end else begin
            checks++;
            if (log_data[0] !== img[0] || log_data[1] !== img[1] || log_addr[1] !== 8'd1) begin
                errors++;
                $display("FAIL after_reset_data: got %h %h required %h %h", log_data[0], log_data[1], img[0], img[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        mem_valid = 1'b0;
        test_reset();
        test_three_words();
        test_bad_header_zero();
        test_bad_header_big();
        test_backpressure();
        test_gaps_and_start();
        test_random_loads();
        test_full_depth();
        test_reset_midload();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
